// File: rtl/lane_demux.sv
// lane_demux: per-lane byte/control demux with framing FSM, ordered-set detect and error counter (counter built only with LANE_DEMUX_ERR_COUNT_EN)
module lane_demux #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES-1:0]   valid_in,
  input  logic [8*LANES-1:0] data_in,
  output logic [8*LANES-1:0] data_out,
  output logic [LANES-1:0]   data_valid,
  output logic [8*LANES-1:0] control,
  output logic [LANES-1:0]   ctrl_valid,
  output logic [LANES-1:0]   in_packet,
  output logic [LANES-1:0]   os_detect,
  output logic [LANES-1:0]   err,
  output logic [CNT_W-1:0]   err_count
);
  typedef enum logic [1:0] {IDLE, PKT, COM_SEEN} state_t;
  localparam logic [7:0] STP = 8'hFB, SDP = 8'h5C, END = 8'hFD, EDB = 8'hFE;
  localparam logic [7:0] SKP = 8'h1C, IDL = 8'h7C, FTS = 8'h3C, COM = 8'hBC;
  logic [LANES-1:0] w_err;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    state_t     r_state, w_nxt;
    logic [7:0] w_sym, r_data, r_ctl;
    logic       w_start, w_end, w_os, w_com, w_known, w_ferr, w_osd;
    logic       r_dv, r_cv, r_pkt, r_os, r_err;
    assign w_sym   = data_in[8*g +: 8];
    assign w_start = (w_sym == STP) || (w_sym == SDP);
    assign w_end   = (w_sym == END) || (w_sym == EDB);
    assign w_os    = (w_sym == SKP) || (w_sym == IDL) || (w_sym == FTS);
    assign w_com   = (w_sym == COM);
    assign w_known = w_start || w_end || w_os || w_com;
    // next state and error/ordered-set decisions; unknown codes leave the state alone
    always_comb begin
      w_nxt  = r_state;
      w_ferr = 1'b0;
      w_osd  = 1'b0;
      if (valid_in[g]) w_nxt = (r_state == PKT) ? PKT : IDLE;
      else if (!w_known) w_ferr = 1'b1;
      else begin
        w_nxt  = w_start ? PKT : w_com ? COM_SEEN : IDLE;
        w_ferr = (r_state == IDLE) ? w_end : (r_state == PKT) ? !w_end : 1'b0;
        w_osd  = (r_state == COM_SEEN) && w_os;
      end
    end
    // registered per-lane outputs and framing state
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_data  <= '0;
        r_ctl   <= '0;
        r_dv    <= 1'b0;
        r_cv    <= 1'b0;
        r_pkt   <= 1'b0;
        r_os    <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_state <= w_nxt;
        if (valid_in[g]) r_data <= w_sym;
        r_ctl   <= (!valid_in[g] && w_known) ? w_sym : 8'h00;
        r_dv    <= valid_in[g];
        r_cv    <= !valid_in[g] && w_known;
        r_pkt   <= (w_nxt == PKT);
        r_os    <= w_osd;
        r_err   <= w_ferr;
      end
    end
    assign w_err[g]           = w_ferr;
    assign data_out[8*g +: 8] = r_data;
    assign control[8*g +: 8]  = r_ctl;
    assign data_valid[g]      = r_dv;
    assign ctrl_valid[g]      = r_cv;
    assign in_packet[g]       = r_pkt;
    assign os_detect[g]       = r_os;
    assign err[g]             = r_err;
  end
`ifdef LANE_DEMUX_ERR_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W+3:0] w_sum;
  // running total plus this cycle's error popcount, wide enough to never wrap
  always_comb begin
    w_sum = {4'b0, r_cnt};
    for (int i = 0; i < LANES; i++) w_sum = w_sum + {{(CNT_W+3){1'b0}}, w_err[i]};
  end
  // saturating error counter, updated on the same edge as the err pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else r_cnt <= (w_sum > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end
  assign err_count = r_cnt;
`else
  logic w_unused_err;
  assign w_unused_err = ^w_err;
  assign err_count    = '0;
`endif
endmodule

// File: tb/tb_lane_demux.sv
// tb_lane_demux: randomized and directed checks of lane_demux against a table-driven reference model
module tb_lane_demux;
  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam int IDLE_S = 0, PKT_S = 1, COM_S = 2;
  localparam int MAXC = 2**CNT_W - 1;
`ifdef LANE_DEMUX_ERR_COUNT_EN
  localparam int SAT_EXP = MAXC;
`else
  localparam int SAT_EXP = 0;
`endif
  logic               clk = 1'b0, reset = 1'b0;
  logic [LANES-1:0]   valid_in = '0;
  logic [8*LANES-1:0] data_in = '0;
  logic [8*LANES-1:0] data_out, control;
  logic [LANES-1:0]   data_valid, ctrl_valid, in_packet, os_detect, err;
  logic [CNT_W-1:0]   err_count;

  always #5 clk = ~clk;

  lane_demux #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .control(control),
    .ctrl_valid(ctrl_valid), .in_packet(in_packet), .os_detect(os_detect),
    .err(err), .err_count(err_count)
  );

  int n_chk = 0, n_pass = 0;

  // symbol classes: 0 start(STP/SDP) 1 end(END/EDB) 2 os(SKP/IDL/FTS) 3 COM 4 data 5 unknown
  int nxt_t [3][5] = '{'{PKT_S, IDLE_S, IDLE_S, COM_S, IDLE_S},
                       '{PKT_S, IDLE_S, IDLE_S, COM_S, PKT_S},
                       '{PKT_S, IDLE_S, IDLE_S, COM_S, IDLE_S}};
  bit err_t [3][5] = '{'{0, 1, 0, 0, 0},
                       '{1, 0, 1, 1, 0},
                       '{0, 0, 0, 0, 0}};

  int               st [LANES];
  logic [7:0]       m_dout [LANES];
  logic [7:0]       m_ctl [LANES];
  logic [LANES-1:0] m_dv, m_cv, m_inp, m_os, m_err;
  int               m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int cls(input bit v, input logic [7:0] b);
    if (v) return 4;
    case (b)
      8'hFB, 8'h5C:        return 0;
      8'hFD, 8'hFE:        return 1;
      8'h1C, 8'h7C, 8'h3C: return 2;
      8'hBC:               return 3;
      default:             return 5;
    endcase
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      st[l] = IDLE_S;
      m_dout[l] = '0;
      m_ctl[l] = '0;
    end
    m_dv = '0; m_cv = '0; m_inp = '0; m_os = '0; m_err = '0;
    m_cnt = 0;
  endtask

  task automatic model(input logic [LANES-1:0] v, input logic [8*LANES-1:0] d);
    int errs;
    int c;
    logic [7:0] b;
    errs = 0;
    for (int l = 0; l < LANES; l++) begin
      b = d[8*l +: 8];
      c = cls(v[l], b);
      m_dv[l] = v[l];
      m_cv[l] = !v[l] && c != 5;
      m_ctl[l] = m_cv[l] ? b : 8'h00;
      if (v[l]) m_dout[l] = b;
      m_os[l] = (st[l] == COM_S) && (c == 2);
      m_err[l] = (c == 5) ? 1'b1 : err_t[st[l]][c];
      if (c != 5) st[l] = nxt_t[st[l]][c];
      m_inp[l] = (st[l] == PKT_S);
      errs += int'(m_err[l]);
    end
`ifdef LANE_DEMUX_ERR_COUNT_EN
    m_cnt = (m_cnt + errs > MAXC) ? MAXC : m_cnt + errs;
`endif
  endtask

  task automatic compare_all();
    logic [8*LANES-1:0] ed, ec;
    for (int l = 0; l < LANES; l++) begin
      ed[8*l +: 8] = m_dout[l];
      ec[8*l +: 8] = m_ctl[l];
    end
    check("data_out", data_out, ed);
    check("data_valid", data_valid, m_dv);
    check("control", control, ec);
    check("ctrl_valid", ctrl_valid, m_cv);
    check("in_packet", in_packet, m_inp);
    check("os_detect", os_detect, m_os);
    check("err", err, m_err);
    check("err_count", err_count, CNT_W'(m_cnt));
  endtask

  task automatic step(input logic [LANES-1:0] v, input logic [8*LANES-1:0] d);
    valid_in = v;
    data_in = d;
    @(posedge clk);
    #1;
    model(v, d);
    compare_all();
  endtask

  // drive lane l with one symbol; other lanes carry data 00
  task automatic one(input int l, input bit v, input logic [7:0] b);
    logic [LANES-1:0] vv;
    logic [8*LANES-1:0] dd;
    vv = '1;
    dd = '0;
    vv[l] = v;
    dd[8*l +: 8] = b;
    step(vv, dd);
  endtask

  task automatic do_reset();
    valid_in = LANES'($urandom);
    data_in = 8*LANES'({$urandom, $urandom});
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    reset = 1'b0;
  endtask

  logic [7:0] codes [8] = '{8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h1C, 8'h7C, 8'h3C, 8'hBC};

  initial begin
    logic [LANES-1:0] rv;
    logic [8*LANES-1:0] rd;
    int r;
    do_reset();
    one(0, 1'b1, 8'hA5);
    check("rst_rel_dout", data_out[7:0], 8'hA5);
    check("rst_rel_dv", data_valid[0], 1'b1);
    // packet framing on lane 1
    one(1, 1'b0, 8'hFB);
    check("pkt_fb_inp", in_packet[1], 1'b1);
    check("pkt_fb_ctl", control[15:8], 8'hFB);
    one(1, 1'b1, 8'h11);
    check("pkt_d1_inp", in_packet[1], 1'b1);
    check("pkt_d1_ctl", control[15:8], 8'h00);
    one(1, 1'b1, 8'h22);
    check("pkt_d2_dout", data_out[15:8], 8'h22);
    one(1, 1'b0, 8'hFD);
    check("pkt_fd_inp", in_packet[1], 1'b0);
    check("pkt_fd_ctl", control[15:8], 8'hFD);
    check("pkt_fd_err", err[1], 1'b0);
    // ordered sets on lane 2
    one(2, 1'b0, 8'hBC);
    check("os_com", os_detect[2], 1'b0);
    one(2, 1'b0, 8'h1C);
    check("os_skp", os_detect[2], 1'b1);
    one(2, 1'b1, 8'h00);
    check("os_once", os_detect[2], 1'b0);
    one(2, 1'b0, 8'hBC);
    one(2, 1'b0, 8'hBC);
    check("os_com2", os_detect[2], 1'b0);
    one(2, 1'b0, 8'h3C);
    check("os_fts", os_detect[2], 1'b1);
    // framing errors on lane 0
    one(0, 1'b0, 8'hFE);
    check("idle_edb_err", err[0], 1'b1);
    check("idle_edb_inp", in_packet[0], 1'b0);
    one(0, 1'b1, 8'h00);
    check("err_pulse", err[0], 1'b0);
    one(0, 1'b0, 8'hFB);
    one(0, 1'b0, 8'h7C);
    check("pkt_idl_err", err[0], 1'b1);
    check("pkt_idl_inp", in_packet[0], 1'b0);
    // unknown code on lane 3 inside a packet
    one(3, 1'b0, 8'hFB);
    one(3, 1'b0, 8'h00);
    check("unk_err", err[3], 1'b1);
    check("unk_cv", ctrl_valid[3], 1'b0);
    check("unk_inp", in_packet[3], 1'b1);
    // asynchronous reset mid-packet
    one(1, 1'b0, 8'hFB);
    #3 reset = 1'b1;
    #1 model_reset();
    check("async_rst_inp", in_packet[1], 1'b0);
    compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
    one(1, 1'b1, 8'h11);
    check("post_rst_idle", in_packet[1], 1'b0);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int l = 0; l < LANES; l++) begin
        r = $urandom_range(0, 9);
        rv[l] = (r < 5);
        rd[8*l +: 8] = (r < 5 || r == 9) ? 8'($urandom) : codes[$urandom_range(0, 7)];
      end
      step(rv, rd);
    end
    // counter saturation
    do_reset();
    for (int n = 0; n < 254; n++) one(0, 1'b0, 8'h00);
    step(4'b1000, 32'h0);
    check("sat_clamp", err_count, CNT_W'(SAT_EXP));
    one(0, 1'b0, 8'h00);
    check("sat_hold", err_count, CNT_W'(SAT_EXP));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
